// File: rtl/led_sequencer_pkg.sv
// Shared types and default sizing for the LED pattern sequencer.
package led_sequencer_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DEF_LED_WIDTH   = 8;
   localparam int DEF_DEPTH       = 8;
   localparam int DEF_DWELL_WIDTH = 8;

   localparam logic [DEF_LED_WIDTH-1:0] DEF_IDLE_PATTERN = 8'h55;

   // One pattern-table slot at the default widths.
   typedef struct packed {
      logic [DEF_LED_WIDTH-1:0]   pattern;
      logic [DEF_DWELL_WIDTH-1:0] dwell;
   } slot_entry_t;

endpackage

// File: rtl/led_sequencer_if.sv
// Configuration, control and status bundle of the LED sequencer.
interface led_sequencer_if
   import led_sequencer_pkg::*;
#(
   parameter int LED_WIDTH   = DEF_LED_WIDTH,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int DWELL_WIDTH = DEF_DWELL_WIDTH
);
   localparam int AW = $clog2(DEPTH);

   logic                   cfg_valid;
   logic                   cfg_ready;
   logic [AW-1:0]          cfg_addr;
   logic [LED_WIDTH-1:0]   cfg_pattern;
   logic [DWELL_WIDTH-1:0] cfg_dwell;
   logic [AW:0]            length;
   logic                   loop;
   logic                   start;
   logic                   stop;
   logic                   busy;
   logic [AW-1:0]          slot;
   logic [LED_WIDTH-1:0]   led;

   modport master (
      output cfg_valid, cfg_addr, cfg_pattern, cfg_dwell, length, loop, start, stop,
      input  cfg_ready, busy, slot, led
   );

   modport slave (
      input  cfg_valid, cfg_addr, cfg_pattern, cfg_dwell, length, loop, start, stop,
      output cfg_ready, busy, slot, led
   );

endinterface

// File: rtl/led_sequencer_prescaler.sv
// Free-running timebase: tick is high while the counter sits at PRESCALE-1.
module led_sequencer_prescaler #(
   parameter int PRESCALE = 50_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic tick
);
   localparam int CW = $clog2(PRESCALE);

   logic [CW-1:0] count;

   assign tick = (count == CW'(PRESCALE - 1));

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clock) begin
      if (reset || clear || tick) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: walks a programmable table, holding each slot for
// (dwell+1) ticks. Define LED_SEQUENCER_ACTIVE_LOW_EN for current-sinking LEDs.
module led_sequencer
   import led_sequencer_pkg::*;
#(
   parameter int                   LED_WIDTH    = DEF_LED_WIDTH,
   parameter int                   DEPTH        = DEF_DEPTH,
   parameter int                   PRESCALE     = 50_000_000,
   parameter int                   DWELL_WIDTH  = DEF_DWELL_WIDTH,
   parameter logic [LED_WIDTH-1:0] IDLE_PATTERN = DEF_IDLE_PATTERN
) (
   input  logic          clock,
   input  logic          reset,
   led_sequencer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [AW-1:0] FIRST_SLOT = '0;

   typedef struct packed {
      logic [LED_WIDTH-1:0]   pattern;
      logic [DWELL_WIDTH-1:0] dwell;
   } entry_t;

   entry_t                 table_q [DEPTH];
   state_t                 state;
   logic [AW-1:0]          slot_q;
   logic [DWELL_WIDTH-1:0] dwell_cnt;
   logic [LW-1:0]          len_q;
   logic                   loop_q;
   logic [LED_WIDTH-1:0]   led_q;

   logic                   tick;
   logic                   wr_en;
   logic                   start_ok;
   logic                   last_slot;
   logic [AW-1:0]          next_slot;
   entry_t                 first_entry;
   entry_t                 next_entry;
   entry_t                 start_entry;

`ifdef LED_SEQUENCER_ACTIVE_LOW_EN
   function automatic logic [LED_WIDTH-1:0] drive(input logic [LED_WIDTH-1:0] p);
      return ~p;
   endfunction
`else
   function automatic logic [LED_WIDTH-1:0] drive(input logic [LED_WIDTH-1:0] p);
      return p;
   endfunction
`endif

   assign wr_en       = bus.cfg_valid && (state == IDLE);
   assign start_ok    = (state == IDLE) && bus.start && !bus.stop &&
                        (bus.length != '0) && (bus.length <= LW'(DEPTH));
   assign last_slot   = ({1'b0, slot_q} == (len_q - LW'(1)));
   assign next_slot   = slot_q + AW'(1);
   assign first_entry = table_q[FIRST_SLOT];
   assign next_entry  = table_q[next_slot];

   // A write to slot 0 on the start edge must be what slot 0 displays.
   always_comb begin
      start_entry = first_entry;
      if (wr_en && (bus.cfg_addr == FIRST_SLOT)) begin
         start_entry = '{pattern: bus.cfg_pattern, dwell: bus.cfg_dwell};
      end
   end

   led_sequencer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .clock (clock),
      .reset (reset),
      .clear (start_ok),
      .tick  (tick)
   );

   // NOTE: the pattern table is plain storage with no reset; slots are
   // undefined until written, which keeps it mappable to RAM/LUT storage.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         table_q[bus.cfg_addr] <= '{pattern: bus.cfg_pattern, dwell: bus.cfg_dwell};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         slot_q    <= '0;
         dwell_cnt <= '0;
         len_q     <= '0;
         loop_q    <= 1'b0;
         led_q     <= drive(IDLE_PATTERN);
      end else begin
         case (state)
            IDLE: begin
               if (start_ok) begin
                  state     <= RUN;
                  slot_q    <= '0;
                  dwell_cnt <= start_entry.dwell;
                  len_q     <= bus.length;
                  loop_q    <= bus.loop;
                  led_q     <= drive(start_entry.pattern);
               end
            end
            RUN: begin
               if (bus.stop) begin
                  state  <= IDLE;
                  slot_q <= '0;
                  led_q  <= drive(IDLE_PATTERN);
               end else if (tick) begin
                  if (dwell_cnt != '0) begin
                     dwell_cnt <= dwell_cnt - DWELL_WIDTH'(1);
                  end else if (!last_slot) begin
                     slot_q    <= next_slot;
                     dwell_cnt <= next_entry.dwell;
                     led_q     <= drive(next_entry.pattern);
                  end else if (loop_q) begin
                     slot_q    <= '0;
                     dwell_cnt <= first_entry.dwell;
                     led_q     <= drive(first_entry.pattern);
                  end else begin
                     state  <= IDLE;
                     slot_q <= '0;
                     led_q  <= drive(IDLE_PATTERN);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.cfg_ready = (state == IDLE);
   assign bus.busy      = (state == RUN);
   assign bus.slot      = slot_q;
   assign bus.led       = led_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed, table-driven bench for led_sequencer with PRESCALE=4.
module tb_led_sequencer;

   typedef struct {
      logic       cfg_valid;
      logic [2:0] cfg_addr;
      logic [7:0] cfg_pattern;
      logic [7:0] cfg_dwell;
      logic [3:0] length;
      logic       loop_en;
      logic       start;
      logic       stop;
      logic [7:0] e_led;
      logic       e_busy;
      logic [2:0] e_slot;
      int         cycles;
   } vec_t;

   localparam logic [7:0] IDLE_LED = 8'h55;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[$];

   led_sequencer_if #(.LED_WIDTH(8), .DEPTH(8), .DWELL_WIDTH(8)) bus ();

   led_sequencer #(
      .LED_WIDTH   (8),
      .DEPTH       (8),
      .PRESCALE    (4),
      .DWELL_WIDTH (8),
      .IDLE_PATTERN(8'h55)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] lit(input logic [7:0] p);
`ifdef LED_SEQUENCER_ACTIVE_LOW_EN
      return ~p;
`else
      return p;
`endif
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      bus.cfg_valid   = 1'b0;
      bus.cfg_addr    = '0;
      bus.cfg_pattern = '0;
      bus.cfg_dwell   = '0;
      bus.length      = '0;
      bus.loop        = 1'b0;
      bus.start       = 1'b0;
      bus.stop        = 1'b0;
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h, want %02h", name, act, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [7:0] led,
                            input logic busy, input logic [2:0] slot);
      check({tag, " led"}, bus.led, lit(led));
      check({tag, " busy"}, 8'(bus.busy), 8'(busy));
      check({tag, " slot"}, 8'(bus.slot), 8'(slot));
      check({tag, " cfg_ready"}, 8'(bus.cfg_ready), 8'(!busy));
   endtask

   function automatic vec_t v_hold(input logic [7:0] led, input logic busy,
                                   input logic [2:0] slot, input int n);
      vec_t v;
      v = '{default: 0};
      v.e_led  = led;
      v.e_busy = busy;
      v.e_slot = slot;
      v.cycles = n;
      return v;
   endfunction

   function automatic vec_t v_wr(input logic [2:0] a, input logic [7:0] p, input logic [7:0] d);
      vec_t v;
      v = v_hold(IDLE_LED, 1'b0, 3'd0, 1);
      v.cfg_valid   = 1'b1;
      v.cfg_addr    = a;
      v.cfg_pattern = p;
      v.cfg_dwell   = d;
      return v;
   endfunction

   function automatic vec_t v_go(input logic [3:0] len, input logic lp, input logic stp,
                                 input logic [7:0] led, input logic busy,
                                 input logic [2:0] slot, input int n);
      vec_t v;
      v = v_hold(led, busy, slot, n);
      v.start   = 1'b1;
      v.length  = len;
      v.loop_en = lp;
      v.stop    = stp;
      return v;
   endfunction

   function automatic vec_t v_stop(input int n);
      vec_t v;
      v = v_hold(IDLE_LED, 1'b0, 3'd0, n);
      v.stop = 1'b1;
      return v;
   endfunction

   task automatic run_vecs(input string phase);
      foreach (vecs[k]) begin
         bus.cfg_valid   = vecs[k].cfg_valid;
         bus.cfg_addr    = vecs[k].cfg_addr;
         bus.cfg_pattern = vecs[k].cfg_pattern;
         bus.cfg_dwell   = vecs[k].cfg_dwell;
         bus.length      = vecs[k].length;
         bus.loop        = vecs[k].loop_en;
         bus.start       = vecs[k].start;
         bus.stop        = vecs[k].stop;
         step();
         idle_inputs();
         for (int i = 0; i < vecs[k].cycles; i++) begin
            check_out($sformatf("%s v%0d c%0d", phase, k, i),
                      vecs[k].e_led, vecs[k].e_busy, vecs[k].e_slot);
            if (i < vecs[k].cycles - 1) step();
         end
      end
      vecs.delete();
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      step();
      step();
      check_out("reset", IDLE_LED, 1'b0, 3'd0);
      reset = 1'b0;

      // Test 1: idle after reset.
      vecs.push_back(v_hold(IDLE_LED, 1'b0, 3'd0, 20));
      run_vecs("t1");

      // Test 2: three-slot one-shot sequence, 16 cycles in RUN.
      vecs.push_back(v_wr(3'd0, 8'h01, 8'd0));
      vecs.push_back(v_wr(3'd1, 8'h02, 8'd1));
      vecs.push_back(v_wr(3'd2, 8'h04, 8'd0));
      vecs.push_back(v_go(4'd3, 1'b0, 1'b0, 8'h01, 1'b1, 3'd0, 4));
      vecs.push_back(v_hold(8'h02, 1'b1, 3'd1, 8));
      vecs.push_back(v_hold(8'h04, 1'b1, 3'd2, 4));
      vecs.push_back(v_hold(IDLE_LED, 1'b0, 3'd0, 4));
      run_vecs("t2");

      // Test 3: looping run, stop lands on a tick edge inside slot 1.
      vecs.push_back(v_go(4'd3, 1'b1, 1'b0, 8'h01, 1'b1, 3'd0, 4));
      vecs.push_back(v_hold(8'h02, 1'b1, 3'd1, 8));
      vecs.push_back(v_hold(8'h04, 1'b1, 3'd2, 4));
      vecs.push_back(v_hold(8'h01, 1'b1, 3'd0, 4));
      vecs.push_back(v_hold(8'h02, 1'b1, 3'd1, 4));
      vecs.push_back(v_stop(3));
      run_vecs("t3");

      // Test 4: cfg_valid held through a run commits only once idle.
      bus.length = 4'd3;
      bus.start  = 1'b1;
      step();
      idle_inputs();
      bus.cfg_valid   = 1'b1;
      bus.cfg_addr    = 3'd1;
      bus.cfg_pattern = 8'hAA;
      bus.cfg_dwell   = 8'd0;
      for (int i = 0; i < 16; i++) begin
         check_out($sformatf("t4 held c%0d", i),
                   (i < 4) ? 8'h01 : ((i < 12) ? 8'h02 : 8'h04), 1'b1,
                   (i < 4) ? 3'd0 : ((i < 12) ? 3'd1 : 3'd2));
         step();
      end
      check_out("t4 first idle", IDLE_LED, 1'b0, 3'd0);
      step();
      bus.cfg_valid = 1'b0;
      vecs.push_back(v_go(4'd3, 1'b0, 1'b0, 8'h01, 1'b1, 3'd0, 4));
      vecs.push_back(v_hold(8'hAA, 1'b1, 3'd1, 4));
      vecs.push_back(v_hold(8'h04, 1'b1, 3'd2, 4));
      vecs.push_back(v_hold(IDLE_LED, 1'b0, 3'd0, 2));
      run_vecs("t4");

      // Test 5: length bounds, full-depth run, start with stop.
      vecs.push_back(v_go(4'd0, 1'b0, 1'b0, IDLE_LED, 1'b0, 3'd0, 3));
      vecs.push_back(v_go(4'd9, 1'b0, 1'b0, IDLE_LED, 1'b0, 3'd0, 3));
      for (int i = 0; i < 8; i++) vecs.push_back(v_wr(3'(i), 8'(1 << i), 8'd0));
      vecs.push_back(v_go(4'd8, 1'b0, 1'b0, 8'h01, 1'b1, 3'd0, 4));
      for (int i = 1; i < 8; i++) vecs.push_back(v_hold(8'(1 << i), 1'b1, 3'(i), 4));
      vecs.push_back(v_hold(IDLE_LED, 1'b0, 3'd0, 3));
      vecs.push_back(v_go(4'd3, 1'b0, 1'b1, IDLE_LED, 1'b0, 3'd0, 3));
      run_vecs("t5");

      // Test 6: reset in slot 2 of a looping run, then restart.
      vecs.push_back(v_go(4'd3, 1'b1, 1'b0, 8'h01, 1'b1, 3'd0, 4));
      vecs.push_back(v_hold(8'h02, 1'b1, 3'd1, 4));
      vecs.push_back(v_hold(8'h04, 1'b1, 3'd2, 2));
      run_vecs("t6a");
      reset = 1'b1;
      step();
      check_out("t6 reset", IDLE_LED, 1'b0, 3'd0);
      reset = 1'b0;
      vecs.push_back(v_go(4'd3, 1'b1, 1'b0, 8'h01, 1'b1, 3'd0, 4));
      vecs.push_back(v_hold(8'h02, 1'b1, 3'd1, 2));
      vecs.push_back(v_stop(2));
      run_vecs("t6b");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
Controller that sequences the board LED bank through a programmable table of patterns, replacing a fixed free-running blink divider. A prescaler generates a timebase tick; a small state machine walks a register-file pattern table, holding each entry for a programmable number of ticks. A configuration port writes the table while the sequencer is idle. The output feeds the top-level open-drain LED drivers.

Parameters:
LED_WIDTH, 8, width of the LED bank and of each pattern entry
DEPTH, 8, number of pattern slots (power of two, at least 2)
PRESCALE, 50_000_000, clock cycles per tick (at least 2)
DWELL_WIDTH, 8, width of the per-slot dwell field
IDLE_PATTERN, 8'h55, LED value driven while idle

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
cfg_valid  in  1  table write request
cfg_ready  out  1  table write accepted when high with cfg_valid
cfg_addr  in  log2(DEPTH)  slot index to write
cfg_pattern  in  LED_WIDTH  LED pattern for slot
cfg_dwell  in  DWELL_WIDTH  slot hold time in ticks, minus one
length  in  log2(DEPTH)+1  number of active slots, sampled on start
loop  in  1  1 = wrap to slot 0 after last slot; 0 = return to idle; sampled on start
start  in  1  one-cycle start pulse
stop  in  1  one-cycle abort pulse
busy  out  1  high in RUN
slot  out  log2(DEPTH)  current slot index
led  out  LED_WIDTH  registered LED drive, 1 = lit

Behaviour:
- Reset values: state IDLE, busy=0, slot=0, led=IDLE_PATTERN, cfg_ready=1, prescaler=0. Table contents are not reset; every slot is undefined until written.
- cfg_ready = (state==IDLE). A write commits at the clock edge where cfg_valid and cfg_ready are both high. cfg_valid in RUN is held off and never dropped or partially applied.
- States: IDLE and RUN.
- IDLE to RUN happens on start with 1 <= length <= DEPTH. If length is 0 or greater than DEPTH, start is ignored.
- On entry to RUN: slot=0, dwell counter = table[0].dwell, prescaler cleared.
- led and slot are registered. led shows table[0].pattern on the cycle after start.
- Prescaler counts 0 to PRESCALE-1 and asserts an internal tick when at PRESCALE-1, then wraps to 0.
- On each tick in RUN:
  - If the dwell counter is nonzero, decrement it.
  - Otherwise advance the slot.
- Slot advance:
  - If slot is not length-1: slot+1, and the dwell counter is loaded from the new slot.
  - If slot is length-1 and loop=1: wrap to slot 0.
  - If slot is length-1 and loop=0: go to IDLE, led=IDLE_PATTERN, slot=0.
- Each slot is displayed for exactly (dwell+1)*PRESCALE cycles.
- stop in RUN forces IDLE on the next edge and overrides a same-cycle tick. stop in IDLE has no effect.
- start in RUN is ignored (no restart).
- start together with an accepted cfg write in IDLE: the write commits and RUN is entered on the same edge. Slot 0 reads the newly written value if cfg_addr==0.
- start together with stop: stop wins, and the block stays in or returns to IDLE.
- reset in mid-sequence returns every output to its reset value on the next edge.
- Prescaler is free-running in IDLE; its value in IDLE is unobservable.

Optional Feature:
LED_SEQUENCER_ACTIVE_LOW_EN
- Defined: led is registered as the bitwise inverse of the selected pattern, for boards whose LEDs sink current. The reset value becomes ~IDLE_PATTERN.
- Undefined: led is active-high exactly as specified above.
- cfg and status behaviour is identical in both builds.

Decomposition:
- Package led_sequencer_pkg holds:
  - the state enumeration (IDLE, RUN);
  - the default LED_WIDTH, DEPTH and DWELL_WIDTH constants;
  - the IDLE_PATTERN default;
  - a slot-entry typedef {pattern, dwell}.
- One sub-module, led_sequencer_prescaler:
  - parameter PRESCALE; inputs clock, reset, clear; output tick;
  - a counter of width $clog2(PRESCALE) with synchronous clear.
- The table register file and the FSM stay in the top.

Test Plan:
All tests use PRESCALE=4.
1. Reset then idle -> led=8'h55, busy=0, cfg_ready=1, slot=0 for 20 cycles.
2. Write slots 0..2 = {8'h01,d0}, {8'h02,d1}, {8'h04,d0}; start with length=3, loop=0 -> led 01 for 4 cycles, 02 for 8, 04 for 4, then 55 with busy=0. Total time in RUN is 16 cycles.
3. Same table with loop=1 -> sequence 01,02,04,01,02 repeats. Pulse stop mid-slot 1 -> led=55 and busy=0 on the next cycle.
4. cfg_valid held during RUN -> cfg_ready=0 and the table is unchanged. The write commits on the first IDLE cycle after the sequence ends.
5. Boundaries:
   - start with length=0 or 9 -> stays IDLE.
   - start with length=8, all dwell=0 -> 32-cycle sequence, slot wraps 7 to IDLE.
   - start and stop in the same cycle -> IDLE.
6. Assert reset during slot 2 of a looping run -> next cycle led=55, slot=0, busy=0. Then start -> led shows slot 0 on the following cycle.
